// File: rtl/starfield_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | starfield_renderer: 2-stage pixel pipeline drawing a scrolling LFSR   |
// | starfield and player ship. Macro STARSOC_BORDER_EN adds a red border. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module starfield_renderer #(
  parameter int          H_ORIGIN   = 16,
  parameter int          V_ORIGIN   = 10,
  parameter int          H_VISIBLE  = 640,
  parameter int          V_VISIBLE  = 480,
  parameter int          SHIP_W     = 16,
  parameter int          SHIP_H     = 16,
  parameter int          SHIP_Y     = 440,
  parameter int          SHIP_SPEED = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [9:0]  ship_x,
  output logic        playing
);

  localparam logic [9:0]  C_H_ORIGIN   = 10'(H_ORIGIN);
  localparam logic [9:0]  C_V_ORIGIN   = 10'(V_ORIGIN);
  localparam logic [9:0]  C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  C_SHIP_W     = 10'(SHIP_W);
  localparam logic [9:0]  C_SHIP_Y     = 10'(SHIP_Y);
  localparam logic [9:0]  C_SHIP_Y_END = 10'(SHIP_Y + SHIP_H - 1);
  localparam logic [9:0]  C_SPEED      = 10'(SHIP_SPEED);
  localparam logic [9:0]  C_SHIP_X_MAX = 10'(H_VISIBLE - SHIP_W);
  localparam logic [9:0]  C_SHIP_X_RST = 10'((H_VISIBLE - SHIP_W) / 2);
  localparam logic [11:0] C_SHIP_RGB   = 12'h0F0;
  localparam logic [11:0] C_STAR_RGB   = 12'hFFF;
`ifdef STARSOC_BORDER_EN
  localparam logic [9:0]  C_H_LAST     = 10'(H_VISIBLE - 1);
  localparam logic [9:0]  C_V_LAST     = 10'(V_VISIBLE - 1);
  localparam logic [11:0] C_BORDER_RGB = 12'hF00;
`endif

  typedef enum logic [0:0] {ST_ATTRACT = 1'b0, ST_PLAY = 1'b1} state_t;

  state_t      r_state;
  logic        r_playing;
  logic [9:0]  r_ship_x;
  logic [9:0]  r_scroll;
  logic        r_vs_prev;
  logic        r_fire_prev;
  logic [1:0]  r_left_sync, r_right_sync, r_fire_sync;
  logic [15:0] r_lfsr;

  logic [9:0]  r_px, r_py;
  logic        r_vid1, r_hs1, r_vs1, r_star1;
  logic [11:0] r_rgb;
  logic        r_hs2, r_vs2;

  logic        w_left, w_right, w_fire, w_frame_tick;
  logic [9:0]  w_ship_x_next, w_scroll_inc;
  logic [9:0]  w_px, w_py, w_sy_sum, w_sy;
  logic [15:0] w_seed_mix, w_lfsr_step, w_lfsr_cur;
  logic        w_ship_hit;
  logic [11:0] w_colour;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_sync  <= 2'b00;
      r_right_sync <= 2'b00;
      r_fire_sync  <= 2'b00;
    end else begin
      r_left_sync  <= {r_left_sync[0], btn_left};
      r_right_sync <= {r_right_sync[0], btn_right};
      r_fire_sync  <= {r_fire_sync[0], btn_fire};
    end
  end

  assign w_left       = r_left_sync[1];
  assign w_right      = r_right_sync[1];
  assign w_fire       = r_fire_sync[1];
  assign w_frame_tick = pix_tick && vsync && !r_vs_prev;
  assign w_scroll_inc = r_scroll + 10'd1;

  always_comb begin
    w_ship_x_next = r_ship_x;
    if (w_left && !w_right)
      w_ship_x_next = (r_ship_x < C_SPEED) ? 10'd0 : r_ship_x - C_SPEED;
    else if (w_right && !w_left)
      w_ship_x_next = (r_ship_x > C_SHIP_X_MAX - C_SPEED) ? C_SHIP_X_MAX : r_ship_x + C_SPEED;
  end

  // Fire history resets to 1 so a button held through reset needs a release first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ATTRACT;
      r_playing   <= 1'b0;
      r_ship_x    <= C_SHIP_X_RST;
      r_scroll    <= 10'd0;
      r_vs_prev   <= 1'b0;
      r_fire_prev <= 1'b1;
    end else begin
      if (pix_tick)
        r_vs_prev <= vsync;
      if (w_frame_tick) begin
        r_scroll    <= (w_scroll_inc == C_V_VIS) ? 10'd0 : w_scroll_inc;
        r_fire_prev <= w_fire;
        case (r_state)
          ST_ATTRACT: begin
            if (w_fire && !r_fire_prev) begin
              r_state   <= ST_PLAY;
              r_playing <= 1'b1;
            end
          end
          ST_PLAY: r_ship_x <= w_ship_x_next;
        endcase
      end
    end
  end

  assign w_px        = x - C_H_ORIGIN;
  assign w_py        = y - C_V_ORIGIN;
  assign w_sy_sum    = w_py + r_scroll;
  assign w_sy        = (w_sy_sum >= C_V_VIS) ? w_sy_sum - C_V_VIS : w_sy_sum;
  assign w_seed_mix  = LFSR_SEED ^ {6'b0, w_sy};
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // Value that belongs to the current pixel: reseeded at the line start, stepped otherwise.
  assign w_lfsr_cur  = (x == C_H_ORIGIN) ? ((w_seed_mix == 16'd0) ? 16'h0001 : w_seed_mix)
                                         : w_lfsr_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= LFSR_SEED;
      r_px    <= 10'd0;
      r_py    <= 10'd0;
      r_vid1  <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_star1 <= 1'b0;
    end else if (pix_tick) begin
      if (video_on)
        r_lfsr <= w_lfsr_cur;
      r_px    <= w_px;
      r_py    <= w_py;
      r_vid1  <= video_on;
      r_hs1   <= hsync;
      r_vs1   <= vsync;
      r_star1 <= video_on && (w_lfsr_cur[7:0] == 8'hFF);
    end
  end

  assign w_ship_hit = r_playing
                   && (r_px >= r_ship_x) && (r_px <= r_ship_x + C_SHIP_W - 10'd1)
                   && (r_py >= C_SHIP_Y) && (r_py <= C_SHIP_Y_END);

  always_comb begin
    w_colour = 12'h000;
    if (r_star1)
      w_colour = C_STAR_RGB;
    if (w_ship_hit)
      w_colour = C_SHIP_RGB;
`ifdef STARSOC_BORDER_EN
    if ((r_px == 10'd0) || (r_px == C_H_LAST) || (r_py == 10'd0) || (r_py == C_V_LAST))
      w_colour = C_BORDER_RGB;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb <= 12'h000;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
    end else if (pix_tick) begin
      r_rgb <= r_vid1 ? w_colour : 12'h000;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  assign rgb       = r_rgb;
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;
  assign ship_x    = r_ship_x;
  assign playing   = r_playing;

endmodule
`default_nettype wire

// File: tb/tb_starfield_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_starfield_renderer: directed bench for starfield_renderer.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_starfield_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic [9:0]  x, y;
  logic        video_on, hsync, vsync;
  logic        btn_left, btn_right, btn_fire;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
  logic [9:0]  ship_x;
  logic        playing;

  int n_checks = 0;
  int n_bad    = 0;
  int tb_scroll;

  logic [11:0] cap[640];
  logic [11:0] prev_cap[640];

  starfield_renderer dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .ship_x(ship_x), .playing(playing)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic tick(input int px, input int py, input logic vid, input logic hs, input logic vs);
    x = 10'(px + 16); y = 10'(py + 10);
    video_on = vid; hsync = hs; vsync = vs; pix_tick = 1'b1;
    @(posedge clk); #1;
    pix_tick = 1'b0;
  endtask

  task automatic frame();
    tick(-16, -10, 1'b0, 1'b0, 1'b0);
    tick(-16, -10, 1'b0, 1'b0, 1'b0);
    tick(-16, -10, 1'b0, 1'b0, 1'b1);
    tb_scroll = (tb_scroll + 1 == 480) ? 0 : tb_scroll + 1;
  endtask

  task automatic do_reset(input logic fire);
    btn_fire = fire; btn_left = 1'b0; btn_right = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tb_scroll = 0;
  endtask

  task automatic capture_line(input int py);
    for (int px = 0; px < 640; px++) begin
      tick(px, py, 1'b1, 1'b0, 1'b0);
      if (px > 0) cap[px-1] = rgb;
    end
    tick(-16, py, 1'b0, 1'b0, 1'b0);
    cap[639] = rgb;
  endtask

  task automatic check_line_model(input string name, input int py, input int sy);
    logic [15:0] l;
    logic [11:0] exp_c;
    int bad_px = -1;
    logic [11:0] got_b = '0, exp_b = '0;
    l = 16'hACE1 ^ 16'(sy);
    if (l == 16'd0) l = 16'h0001;
    for (int px = 0; px < 640; px++) begin
      if (px > 0) l = lfsr_step(l);
      exp_c = (l[7:0] == 8'hFF) ? 12'hFFF : 12'h000;
`ifdef STARSOC_BORDER_EN
      if (px == 0 || px == 639 || py == 0 || py == 479) exp_c = 12'hF00;
`endif
      if (cap[px] !== exp_c && bad_px < 0) begin
        bad_px = px; got_b = cap[px]; exp_b = exp_c;
      end
    end
    n_checks++;
    if (bad_px >= 0) begin
      n_bad++;
      $display("FAIL %s: py=%0d px=%0d rgb got %h want %h", name, py, bad_px, got_b, exp_b);
    end
  endtask

  task automatic test_reset();
    bit [4:0] hs_pat = 5'b01101;
    bit [4:0] vs_pat = 5'b00110;
    do_reset(1'b0);
    n_checks += 5;
    if (rgb !== 12'h000)   begin n_bad++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    if (ship_x !== 10'd312) begin n_bad++; $display("FAIL reset_ship_x: got %0d want 312", ship_x); end
    if (playing !== 1'b0)  begin n_bad++; $display("FAIL reset_playing: got %b want 0", playing); end
    if (hsync_out !== 1'b0) begin n_bad++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
    if (vsync_out !== 1'b0) begin n_bad++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
    for (int i = 0; i < 5; i++) begin
      tick(-16, -10, 1'b0, hs_pat[i], vs_pat[i]);
      n_checks += 3;
      if (hsync_out !== ((i > 0) ? hs_pat[i-1] : 1'b0)) begin
        n_bad++; $display("FAIL sync_delay_h: tick %0d got %b want %b", i, hsync_out, (i > 0) ? hs_pat[i-1] : 1'b0);
      end
      if (vsync_out !== ((i > 0) ? vs_pat[i-1] : 1'b0)) begin
        n_bad++; $display("FAIL sync_delay_v: tick %0d got %b want %b", i, vsync_out, (i > 0) ? vs_pat[i-1] : 1'b0);
      end
      if (rgb !== 12'h000) begin n_bad++; $display("FAIL idle_rgb: tick %0d got %h want 000", i, rgb); end
    end
    tb_scroll = 1;  // the vsync pattern above holds one rising edge
  endtask

  task automatic test_fire();
    do_reset(1'b1);
    frame(); frame();
    n_checks++;
    if (playing !== 1'b0) begin n_bad++; $display("FAIL fire_through_reset: playing got %b want 0", playing); end
    btn_fire = 1'b0; btn_left = 1'b1;
    frame();
    btn_left = 1'b0;
    n_checks += 2;
    if (playing !== 1'b0) begin n_bad++; $display("FAIL fire_released: playing got %b want 0", playing); end
    if (ship_x !== 10'd312) begin n_bad++; $display("FAIL attract_no_move: ship_x got %0d want 312", ship_x); end
    btn_fire = 1'b1;
    frame();
    n_checks++;
    if (playing !== 1'b1) begin n_bad++; $display("FAIL fire_start: playing got %b want 1", playing); end
    repeat (3) frame();
    n_checks += 2;
    if (playing !== 1'b1) begin n_bad++; $display("FAIL fire_hold: playing got %b want 1", playing); end
    if (ship_x !== 10'd312) begin n_bad++; $display("FAIL fire_hold_ship: ship_x got %0d want 312", ship_x); end
    btn_fire = 1'b0;
  endtask

  task automatic test_move();
    int exp_x;
    btn_left = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      frame();
      exp_x = (312 - 4 * k < 0) ? 0 : 312 - 4 * k;
      n_checks++;
      if (ship_x !== 10'(exp_x)) begin n_bad++; $display("FAIL move_left: frame %0d got %0d want %0d", k, ship_x, exp_x); end
    end
    btn_left = 1'b0; btn_right = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      frame();
      exp_x = (4 * k > 624) ? 624 : 4 * k;
      n_checks++;
      if (ship_x !== 10'(exp_x)) begin n_bad++; $display("FAIL move_right: frame %0d got %0d want %0d", k, ship_x, exp_x); end
    end
    btn_left = 1'b1;
    repeat (3) frame();
    n_checks++;
    if (ship_x !== 10'd624) begin n_bad++; $display("FAIL move_both: got %0d want 624", ship_x); end
    btn_right = 1'b0;
    repeat (78) frame();
    btn_left = 1'b0;
    n_checks++;
    if (ship_x !== 10'd312) begin n_bad++; $display("FAIL move_back: got %0d want 312", ship_x); end
  endtask

  task automatic test_ship_pixel();
    int pxs[6] = '{311, 312, 327, 328, 312, 312};
    int pys[6] = '{440, 440, 455, 440, 439, 456};
    bit [5:0] is_ship = 6'b000110;
    tick(-16, 440, 1'b0, 1'b0, 1'b0);
    tick(-16, 440, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(pxs[i], pys[i], 1'b1, 1'b0, 1'b0);
      if (i == 1) begin
        n_checks++;
        if (rgb !== 12'h000) begin n_bad++; $display("FAIL ship_latency: got %h want 000 after one tick", rgb); end
      end
      tick(-16, 440, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (is_ship[i] && rgb !== 12'h0F0) begin
        n_bad++; $display("FAIL ship_hit: px=%0d py=%0d got %h want 0f0", pxs[i], pys[i], rgb);
      end else if (!is_ship[i] && rgb === 12'h0F0) begin
        n_bad++; $display("FAIL ship_miss: px=%0d py=%0d got %h want not 0f0", pxs[i], pys[i], rgb);
      end
    end
    tick(312, 445, 1'b1, 1'b0, 1'b0);
    tick(-16, 445, 1'b0, 1'b0, 1'b0);
    x = 10'd0; y = 10'd0; video_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rgb !== 12'h0F0) begin n_bad++; $display("FAIL hold_no_tick: got %h want 0f0", rgb); end
    tick(-16, 445, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rgb !== 12'h000) begin n_bad++; $display("FAIL blank_rgb: got %h want 000", rgb); end
  endtask

  task automatic test_stars();
    int bad_px;
    capture_line(6);
    check_line_model("stars_n", 6, (6 + tb_scroll) % 480);
    foreach (cap[i]) prev_cap[i] = cap[i];
    frame();
    capture_line(5);
    check_line_model("stars_n1", 5, (5 + tb_scroll) % 480);
    bad_px = -1;
    foreach (cap[i]) if (cap[i] !== prev_cap[i] && bad_px < 0) bad_px = i;
    n_checks++;
    if (bad_px >= 0) begin
      n_bad++; $display("FAIL scroll_shift: px=%0d got %h want %h", bad_px, cap[bad_px], prev_cap[bad_px]);
    end
    for (int i = 0; i < 500 && tb_scroll != 479; i++) frame();
    capture_line(0);
    check_line_model("scroll_479", 0, 479);
    foreach (cap[i]) prev_cap[i] = cap[i];
    frame();
    capture_line(0);
    check_line_model("scroll_wrap0", 0, 0);
    capture_line(479);
    check_line_model("scroll_wrap479", 479, 479);
    bad_px = -1;
    foreach (cap[i]) if (cap[i] !== prev_cap[i] && bad_px < 0) bad_px = i;
    n_checks++;
    if (bad_px >= 0) begin
      n_bad++; $display("FAIL scroll_wrap_eq: px=%0d got %h want %h", bad_px, cap[bad_px], prev_cap[bad_px]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] l;
    logic [11:0] exp_c;
    btn_left = 1'b1;
    frame();
    btn_left = 1'b0;
    n_checks++;
    if (ship_x !== 10'd308) begin n_bad++; $display("FAIL pre_reset_move: got %0d want 308", ship_x); end
    tick(308, 440, 1'b1, 1'b0, 1'b0);
    tick(309, 440, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb !== 12'h0F0) begin n_bad++; $display("FAIL pre_reset_rgb: got %h want 0f0", rgb); end
    #2 reset = 1'b1;
    #1;
    n_checks += 3;
    if (rgb !== 12'h000)   begin n_bad++; $display("FAIL async_reset_rgb: got %h want 000", rgb); end
    if (ship_x !== 10'd312) begin n_bad++; $display("FAIL async_reset_ship: got %0d want 312", ship_x); end
    if (playing !== 1'b0)  begin n_bad++; $display("FAIL async_reset_playing: got %b want 0", playing); end
    @(posedge clk);
    #3 reset = 1'b0;
    tb_scroll = 0;
    l = 16'hACE1 ^ 16'd100;
    exp_c = (l[7:0] == 8'hFF) ? 12'hFFF : 12'h000;
`ifdef STARSOC_BORDER_EN
    exp_c = 12'hF00;
`endif
    tick(0, 100, 1'b1, 1'b0, 1'b0);
    tick(-16, 100, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rgb !== exp_c) begin n_bad++; $display("FAIL post_reset_px0: got %h want %h", rgb, exp_c); end
    tick(312, 440, 1'b1, 1'b0, 1'b0);
    tick(-16, 440, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rgb === 12'h0F0) begin n_bad++; $display("FAIL post_reset_ship: got %h want not 0f0", rgb); end
  endtask

  initial begin
    reset = 1'b0; pix_tick = 1'b0; x = '0; y = '0;
    video_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    tb_scroll = 0;
    test_reset();
    test_fire();
    test_move();
    test_ship_pixel();
    test_stars();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
